// File: rtl/queue_drain.sv
// ---------------------------------------------------------------------------
// queue_drain
//
// Read side of a round-robin entry queue. The queue itself owns the storage
// and the write pointer; this block keeps its own read pointer and an
// occupancy count, and presents entries oldest-first through a registered
// output slot.
//
// Handshake (out_valid / out_ready): a transfer happens on a rising edge
// where out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, out_valid and out_data hold their values. out_valid
// never depends combinationally on out_ready.
//
// Capacity is NUM_ENTRIES + 1: NUM_ENTRIES slots in the queue plus the
// output register. full reflects only the queue occupancy (count).
//
// Ports
//   clk        clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   entries    queue contents, packed [NUM_ENTRIES-1:0][BIT_WIDTH-1:0]
//   wr_en      queue write enable this cycle (push request)
//   wr_ptr_d   queue's next write pointer, adopted as read pointer on flush
//   flush      synchronous discard of all queued and held data
//   out_ready  consumer accepts out_data this cycle
//   out_valid  out_data holds an unconsumed entry
//   out_data   registered entry, oldest first
//   count      entries written but not yet loaded into out_data
//   empty      count == 0
//   full       count == NUM_ENTRIES; producer must drop wr_en
//   overflow   sticky flag: wr_en seen while full
// ---------------------------------------------------------------------------
module queue_drain #(
    parameter  int NUM_ENTRIES = 8,
    parameter  int BIT_WIDTH   = 8,
    localparam int PTR_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_ENTRIES-1:0][BIT_WIDTH-1:0] entries,
    input  logic                                  wr_en,
    input  logic [PTR_W-1:0]                      wr_ptr_d,
    input  logic                                  flush,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic [BIT_WIDTH-1:0]                  out_data,
    output logic [PTR_W:0]                        count,
    output logic                                  empty,
    output logic                                  full,
    output logic                                  overflow
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(NUM_ENTRIES);

    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             load;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A write while full is the producer's error; it is flagged, not counted.
    assign push = wr_en & ~full;

    // Refill the output slot whenever it is free or being emptied this edge.
    assign load = ~empty & (~out_valid | out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            // overflow is sticky and independent of flush.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end

            if (flush) begin
                // Re-align to the queue's next write slot; anything written
                // in this same cycle lands behind the new read pointer.
                count     <= '0;
                out_valid <= 1'b0;
                rd_ptr    <= wr_ptr_d;
            end else begin
                if (load) begin
                    out_data  <= entries[rd_ptr];
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end

                case ({push, load})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_queue_drain.sv
// ---------------------------------------------------------------------------
// tb_queue_drain
//
// Bench for queue_drain with NUM_ENTRIES=8, BIT_WIDTH=8. A small model of the
// feeding queue writes entries into its array and advances its write pointer
// whenever wr_en is high and full is low. Inputs are driven on the falling
// edge; outputs are sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_queue_drain;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int PW = 3;

    // clock / reset
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic [N-1:0][W-1:0] q_entries;
    logic                wr_en;
    logic [W-1:0]        wdata;
    logic [PW-1:0]       wr_ptr_d;
    logic                flush;
    logic                out_ready;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [PW:0]         count;
    logic                empty;
    logic                full;
    logic                overflow;

    queue_drain #(.NUM_ENTRIES(N), .BIT_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .entries   (q_entries),
        .wr_en     (wr_en),
        .wr_ptr_d  (wr_ptr_d),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    // feeding queue model: write slot gated by full, pointer resets with the DUT
    logic [PW-1:0] q_wr_ptr;

    assign wr_ptr_d = q_wr_ptr + PW'(wr_en & ~full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_wr_ptr <= '0;
        end else if (wr_en && !full) begin
            q_entries[q_wr_ptr] <= wdata;
            q_wr_ptr            <= q_wr_ptr + PW'(1);
        end
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // one clock cycle: drive at falling edge, account for transfer/push, wait
    task automatic cycle(input logic we, input logic [W-1:0] d, input logic rdy, input logic fl);
        logic [W-1:0] e;
        wr_en     = we;
        wdata     = d;
        out_ready = rdy;
        flush     = fl;
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_extra: got 0x%0h with no entry expected at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", {24'd0, out_data}, {24'd0, e});
                end
            end
            if (we && !full) exp_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        wr_en     = 1'b0;
        wdata     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [W-1:0] ed,
                            input logic [PW:0] ec, input logic ef, input logic ee, input logic eo);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, "_data"},  {24'd0, out_data},  {24'd0, ed});
        chk({tag, "_count"}, {28'd0, count},     {28'd0, ec});
        chk({tag, "_full"},  {31'd0, full},      {31'd0, ef});
        chk({tag, "_empty"}, {31'd0, empty},     {31'd0, ee});
        chk({tag, "_ovf"},   {31'd0, overflow},  {31'd0, eo});
    endtask

    // table-driven vectors: inputs for one cycle and the outputs after that edge
    typedef struct {
        logic         we;
        logic [W-1:0] d;
        logic         rdy;
        logic         fl;
        logic         ev;
        logic [W-1:0] ed;
        logic [PW:0]  ec;
        logic         ef;
        logic         ee;
        logic         eo;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];

    function automatic vec_t mkv(logic we, logic [W-1:0] d, logic rdy, logic fl, logic ev,
                                 logic [W-1:0] ed, logic [PW:0] ec, logic ef, logic ee, logic eo);
        vec_t v;
        v.we = we; v.d = d; v.rdy = rdy; v.fl = fl;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef; v.ee = ee; v.eo = eo;
        return v;
    endfunction

    task automatic apply_vec(input string tag, input vec_t v);
        cycle(v.we, v.d, v.rdy, v.fl);
        chk_outs(tag, v.ev, v.ed, v.ec, v.ef, v.ee, v.eo);
    endtask

    initial begin
        int budget;
        logic we_r;
        n_pass  = 0;
        n_total = 0;

        // three entries streamed with out_ready held high
        t1.push_back(mkv(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0));
        t1.push_back(mkv(1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 8'hA1, 4'd1, 1'b0, 1'b0, 1'b0));
        t1.push_back(mkv(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA2, 4'd1, 1'b0, 1'b0, 1'b0));
        t1.push_back(mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 4'd0, 1'b0, 1'b1, 1'b0));
        t1.push_back(mkv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA3, 4'd0, 1'b0, 1'b1, 1'b0));

        // ten writes with out_ready low: first held in out_data, queue fills to 8,
        // the last write arrives while full and raises overflow
        for (int i = 0; i < 10; i++) begin
            logic [PW:0] c;
            c = (i == 0) ? 4'd1 : ((i > 8) ? 4'd8 : 4'(i));
            t2.push_back(mkv(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, (i >= 1), (i >= 1) ? 8'hB0 : 8'h00,
                             c, (c == 4'd8), 1'b0, (i == 9)));
        end

        // reset state
        reset = 1'b0;
        do_reset();
        #1;
        chk_outs("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);

        // basic streaming, 2-edge latency
        foreach (t1[i]) apply_vec($sformatf("stream%0d", i), t1[i]);
        chk("stream_sb_empty", exp_q.size(), 0);

        // fill to full and overflow with the first entry held stable
        do_reset();
        foreach (t2[i]) apply_vec($sformatf("fill%0d", i), t2[i]);

        // drain five, leaving out_valid=1 and count=3, then async reset mid-cycle
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", {28'd0, count}, 32'd3);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        wr_en = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // steady push/pop across two read-pointer wraps
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        chk("wrap_fill_count", {28'd0, count}, 32'd7);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'h48 + 8'(i), 1'b1, 1'b0);
            chk($sformatf("wrap_count%0d", i), {28'd0, count}, 32'd7);
        end
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 40) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            budget++;
        end
        chk("wrap_drained", exp_q.size(), 0);

        // flush with a concurrent write; read pointer adopts wr_ptr_d (5)
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        chk("preflush_count", {28'd0, count}, 32'd3);
        chk("preflush_valid", {31'd0, out_valid}, 32'd1);
        cycle(1'b1, 8'hC4, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_count", {28'd0, count}, 32'd0);
        chk("flush_empty", {31'd0, empty}, 32'd1);
        cycle(1'b1, 8'hD0, 1'b1, 1'b0);
        chk("postflush_count", {28'd0, count}, 32'd1);
        chk("postflush_valid0", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("postflush_valid1", {31'd0, out_valid}, 32'd1);
        chk("postflush_data", {24'd0, out_data}, 32'hD0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("postflush_sb_empty", exp_q.size(), 0);

        // random traffic with a producer that honours full
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            we_r = ($urandom_range(0, 1) == 1) && !full;
            cycle(we_r, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0);
        end
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 40) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            budget++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_valid", {31'd0, out_valid}, 32'd0);
        chk("rand_empty", {31'd0, empty}, 32'd1);
        chk("rand_ovf", {31'd0, overflow}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
